// File: rtl/cmul_seq.sv
// Sequential complex multiplier: z = a*b using one shared signed 8x8 multiplier
// stepped over four cycles, with valid/ready handshakes on both sides.
module cmul_seq (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  a_real,
    input  logic signed [7:0]  a_imag,
    input  logic signed [7:0]  b_real,
    input  logic signed [7:0]  b_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] z_real,
    output logic signed [15:0] z_imag,
    output logic               busy,
    output logic [7:0]         op_count
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic signed [7:0]  ar_q, ai_q, br_q, bi_q;
    logic signed [7:0]  ar_d, ai_d, br_d, bi_d;
    logic signed [16:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic signed [15:0] z_real_q, z_real_d, z_imag_q, z_imag_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         op_count_q, op_count_d;

    logic               accept;
    logic signed [7:0]  mul_x, mul_y;
    logic signed [15:0] prod;
    logic signed [16:0] prod_ext;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Steps 0,2 use ar; 1,3 use ai. Steps 0,3 use br; 1,2 use bi.
    assign mul_x    = step_q[0] ? ai_q : ar_q;
    assign mul_y    = (step_q[0] ^ step_q[1]) ? bi_q : br_q;
    assign prod     = mul_x * mul_y;
    assign prod_ext = {prod[15], prod};

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        ar_d        = ar_q;
        ai_d        = ai_q;
        br_d        = br_q;
        bi_d        = bi_q;
        acc_r_d     = acc_r_q;
        acc_i_d     = acc_i_q;
        z_real_d    = z_real_q;
        z_imag_d    = z_imag_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                step_d = step_q + 2'd1;
                case (step_q)
                    2'd0: acc_r_d = prod_ext;
                    2'd1: acc_r_d = acc_r_q - prod_ext;
                    2'd2: acc_i_d = prod_ext;
                    default: begin
                        acc_i_d     = acc_i_q + prod_ext;
                        z_real_d    = acc_r_q[15:0];
                        z_imag_d    = acc_i_d[15:0];
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                if (out_ready) begin
                    op_count_d  = op_count_q + 8'd1;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance overrides the DONE->IDLE exit for back-to-back issue.
        if (accept) begin
            ar_d    = a_real;
            ai_d    = a_imag;
            br_d    = b_real;
            bi_d    = b_imag;
            step_d  = 2'd0;
            state_d = S_MUL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            z_real_q    <= '0;
            z_imag_q    <= '0;
            out_valid_q <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            ar_q        <= ar_d;
            ai_q        <= ai_d;
            br_q        <= br_d;
            bi_q        <= bi_d;
            acc_r_q     <= acc_r_d;
            acc_i_q     <= acc_i_d;
            z_real_q    <= z_real_d;
            z_imag_q    <= z_imag_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z_real    = z_real_q;
    assign z_imag    = z_imag_q;
    assign busy      = (state_q == S_MUL);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_cmul_seq.sv
// Directed bench for cmul_seq: vector table of complex products plus
// backpressure, mid-operation reset and op_count wrap sequences.
module tb_cmul_seq;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  a_real, a_imag, b_real, b_imag;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] z_real, z_imag;
    logic               busy;
    logic [7:0]         op_count;

    cmul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_real   (a_real),
        .a_imag   (a_imag),
        .b_real   (b_real),
        .b_imag   (b_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z_real   (z_real),
        .z_imag   (z_imag),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0]  ar, ai, br, bi;
        logic signed [15:0] zr, zi;
    } vec_t;

    vec_t       vecs [7];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cmodel(input logic signed [7:0] ar, ai, br, bi);
        int re, im;
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re[15:0], im[15:0]};
    endfunction

    task automatic drive_ops(input logic signed [7:0] ar, ai, br, bi);
        a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    endtask

    task automatic scramble_ops();
        a_real = 8'($urandom); a_imag = 8'($urandom);
        b_real = 8'($urandom); b_imag = 8'($urandom);
    endtask

    // Called just after the acceptance edge; returns edges until out_valid.
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 12) begin
            chk("busy_in_mul", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt++;
        chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hs_op_count", {24'd0, op_count}, {24'd0, exp_cnt});
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input bit hs);
        int n;
        chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        drive_ops(v.ar, v.ai, v.br, v.bi);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_ops();
        wait_result(n);
        chk("latency", n, 32'd4);
        chk("z_real", 32'(v.zr), 32'(z_real));
        chk("z_imag", 32'(v.zi), 32'(z_imag));
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        if (hs) handshake();
    endtask

    initial begin
        int         n;
        logic [31:0] cm;
        logic [7:0]  idx;
        vec_t        bp;

        vecs[0] = '{8'sd1,    8'sd2,    8'sd3,    8'sd4,    -16'sd5,   16'sd10};
        vecs[1] = '{8'sd2,    8'sd4,    8'sd6,    8'sd8,    -16'sd20,  16'sd40};
        vecs[2] = '{8'sd1,    8'sd3,    8'sd5,    8'sd7,    -16'sd16,  16'sd22};
        vecs[3] = '{8'sd3,    8'sd4,    8'sd5,    8'sd6,    -16'sd9,   16'sd38};
        vecs[4] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, 16'sd0,    16'sh8000};
        vecs[5] = '{-8'sd128, 8'sd127,  -8'sd128, -8'sd128, 16'sd32640, 16'sd128};
        vecs[6] = '{8'sd127,  8'sd127,  8'sd127,  -8'sd128, 16'sd32385, -16'sd127};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_ops(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_z_real", 32'(z_real), 32'd0);
        chk("rst_z_imag", 32'(z_imag), 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b1);
        chk("seq_op_count", {24'd0, op_count}, 32'd7);

        // Backpressure then back-to-back issue on the handshake edge.
        bp = '{8'sd5, -8'sd3, 8'sd2, 8'sd9, 16'sd37, 16'sd39};
        run_op(bp, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_z_real", 32'(z_real), 32'sd37);
            chk("bp_z_imag", 32'(z_imag), 32'sd39);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_ops(8'sd1, 8'sd2, 8'sd1, 8'sd2);
        #1;
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        scramble_ops();
        exp_cnt++;
        chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_op_count", {24'd0, op_count}, {24'd0, exp_cnt});
        wait_result(n);
        chk("b2b_latency", n, 32'd4);
        chk("b2b_z_real", 32'(z_real), -32'sd3);
        chk("b2b_z_imag", 32'(z_imag), 32'sd4);
        handshake();

        // Reset while the multiplier is on step 2.
        in_valid = 1'b1;
        drive_ops(8'sd3, 8'sd4, 8'sd5, 8'sd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_z_real", 32'(z_real), 32'd0);
        chk("mrst_z_imag", 32'(z_imag), 32'd0);
        chk("mrst_op_count", {24'd0, op_count}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("mrst_no_valid", {31'd0, out_valid}, 32'd0);
        end

        // 256 back-to-back operations with in_valid noise while in MUL.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_ops(8'sd0, 8'sd0, -8'sd1, 8'sd7);
        for (int e = 0; e <= 1280; e++) begin
            @(posedge clk); #1;
            if ((e % 5) == 4) begin
                idx = 8'(e / 5);
                cm = cmodel(idx, 8'(idx * 3), 8'(255 - idx), 8'sd7);
                chk("cnt_out_valid", {31'd0, out_valid}, 32'd1);
                chk("cnt_z", {z_real, z_imag}, cm);
                chk("cnt_op_count", {24'd0, op_count}, {24'd0, idx});
            end
            if (((e + 1) % 5) == 0 && (e + 1) <= 1275) begin
                idx = 8'((e + 1) / 5);
                in_valid = 1'b1;
                drive_ops(idx, 8'(idx * 3), 8'(255 - idx), 8'sd7);
            end else if ((e + 1) == 1280) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom);
                scramble_ops();
            end
        end
        in_valid = 1'b0;
        chk("wrap_op_count", {24'd0, op_count}, 32'd0);
        chk("wrap_out_valid", {31'd0, out_valid}, 32'd0);
        chk("wrap_idle_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmul_seq.md
CMUL_SEQ -- requirements
Module: cmul_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block will accept operands on this edge.
REQ-006 a_real, a_imag, b_real, b_imag  input  8 each  signed two's-complement operands.
REQ-007 out_valid  output  1  z_real/z_imag hold a completed product.
REQ-008 out_ready  input  1  consumer takes the result on this edge.
REQ-009 z_real, z_imag  output  16 each  signed product (a*b) real and imaginary parts.
REQ-010 busy  output  1  high in MUL state.
REQ-011 op_count  output  8  number of completed output handshakes, modulo 256.

Function
REQ-012 The block SHALL compute z = a*b with ONE shared signed 8x8 multiplier, time-multiplexed over 4 cycles.
REQ-013 States SHALL be IDLE, MUL and DONE; a 2-bit step counter SHALL run 0..3 in MUL.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in DONE only while out_ready=1, and 0 otherwise.
REQ-015 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1: operands are registered, the step counter is cleared, and the state becomes MUL.
REQ-016 Operand inputs SHALL be ignored at all times except the acceptance edge.
REQ-017 MUL steps SHALL be:
- step0: acc_r = ar*br
- step1: acc_r = acc_r - ai*bi
- step2: acc_i = ar*bi
- step3: acc_i = acc_i + ai*br
REQ-018 Accumulators SHALL be at least 17 bits wide; z_real and z_imag SHALL be the low 16 bits, i.e. two's-complement wrap with no saturation.
REQ-019 On the step3 edge, z_real and z_imag SHALL load the results, out_valid SHALL go to 1, and the state becomes DONE.
REQ-020 Latency: with acceptance at edge E0, out_valid SHALL be first high after edge E4.
REQ-021 In DONE, out_valid, z_real and z_imag SHALL hold stable until an edge with out_ready=1.
REQ-022 On an output handshake (DONE, out_ready=1), op_count SHALL increment with wrap 255->0.
REQ-023 Output handshake with in_valid=0: the state SHALL become IDLE and out_valid SHALL become 0.
REQ-024 Output handshake with in_valid=1 on the same edge: the new operands SHALL be accepted, the state goes directly to MUL, and out_valid becomes 0. Minimum issue interval is 5 cycles.
REQ-025 Outside DONE, out_valid SHALL be 0; z_real and z_imag SHALL retain the last result.
REQ-026 busy SHALL equal (state==MUL).
REQ-027 in_valid SHALL be ignored during MUL; no queueing.

Reset
REQ-028 On any edge with rst=1, regardless of state (including mid-MUL and DONE), the block SHALL:
- enter IDLE
- clear the step counter and accumulators
- set out_valid=0, busy=0, z_real=0, z_imag=0, op_count=0
REQ-029 rst SHALL take priority over every handshake on the same edge; an in-flight operation SHALL be discarded with no output.
REQ-030 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-031 Basic: (1+2j)*(3+4j) with out_ready=1 -> out_valid after E4, z_real=-5, z_imag=10, op_count=1.
REQ-032 Sequence: (2+4j)(6+8j), (1+3j)(5+7j), (3+4j)(5+6j) -> results -20+40j, -16+22j, -9+38j, in that order, with op_count=3.
REQ-033 Wrap: (-128-128j)*(-128-128j) -> z_real=0, z_imag=-32768 (0x8000); (-128+127j)*(-128-128j) -> z_real=32640, z_imag=128.
REQ-034 Backpressure and back-to-back:
- hold out_ready=0 for 3 cycles after out_valid -> z stable, in_ready=0, busy=0
- then out_ready=1 with in_valid=1 carrying (1+2j)(1+2j) -> accepted on the same edge, next result -3+4j exactly 4 edges later
REQ-035 Reset: assert rst at step2 of (3+4j)(5+6j) -> out_valid never asserts, z=0, op_count=0, in_ready=1 the cycle after rst drops.
REQ-036 Counter: 256 back-to-back operations -> op_count wraps to 0; in_valid toggled during MUL -> no extra acceptances.
